// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state encoding and SRAM geometry for the SRAM arbiter
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } arb_state_e;

  localparam int SRAM_AW = 8;
  localparam int SRAM_DW = 256;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant with a last-granted pointer
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [N-1:0] req,
  input  logic         update_en,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] cand;
  logic [PW-1:0] gnt_idx;
  logic          found;

  // Walk the ports starting just after the last winner, wrapping at N-1.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    gnt_idx = '0;
    cand    = ptr_q;
    for (int k = 0; k < N; k++) begin
      cand = (cand == PW'(N - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gnt_idx     = cand;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ptr_q <= PW'(N - 1);
    end else if (update_en && found) begin
      ptr_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/sram_1rw_arbiter.sv
// rtl/sram_1rw_arbiter.sv - shares one 1RW SRAM macro between ports with idle low-voltage control
module sram_1rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NPORTS-1:0]         req_valid,
  output logic [NPORTS-1:0]         req_ready,
  input  logic [NPORTS-1:0]         req_write,
  input  logic [NPORTS*SRAM_AW-1:0] req_addr,
  input  logic [NPORTS*SRAM_DW-1:0] req_wdata,
  output logic [NPORTS-1:0]         rsp_valid,
  output logic [SRAM_DW-1:0]        rsp_rdata,
  output logic                      sram_valid,
  output logic                      sram_write,
  output logic [SRAM_AW-1:0]        sram_addr,
  output logic [SRAM_DW-1:0]        sram_wdata,
  input  logic [SRAM_DW-1:0]        sram_rdata,
  output logic                      sram_volt_sel,
  output logic                      busy
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [WW-1:0]     wake_q, wake_d;
  logic [NPORTS-1:0] arb_req;
  logic [NPORTS-1:0] grant;
  logic [NPORTS-1:0] rsp_pend_q;
  logic              any_valid;

  assign any_valid = |req_valid;
  assign arb_req   = (resetn && state_q == ACTIVE) ? req_valid : '0;

  rr_arbiter #(.N(NPORTS)) u_rr (
    .clock    (clock),
    .resetn   (resetn),
    .req      (arb_req),
    .update_en(resetn),
    .grant    (grant)
  );

  assign req_ready = grant;

  always_comb begin
    sram_valid = |grant;
    sram_write = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant[i]) begin
        sram_write = req_write[i];
        sram_addr  = req_addr[i*SRAM_AW +: SRAM_AW];
        sram_wdata = req_wdata[i*SRAM_DW +: SRAM_DW];
      end
    end
  end

  // The macro returns read data one cycle after the access; the pending flag tracks the owner.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rsp_pend_q <= '0;
    end else begin
      rsp_pend_q <= grant & ~req_write;
    end
  end

  assign rsp_valid = resetn ? rsp_pend_q : '0;
  assign rsp_rdata = sram_rdata;

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    case (state_q)
      ACTIVE: begin
        if (any_valid) begin
          idle_d = '0;
        end else if (idle_q == IW'(IDLE_CYCLES - 1)) begin
          state_d = SLEEP;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      SLEEP: begin
        wake_d = '0;
        if (any_valid) begin
          state_d = WAKE;
        end
      end
      WAKE: begin
        if (wake_q == WW'(WAKE_CYCLES - 1)) begin
          state_d = ACTIVE;
          wake_d  = '0;
          idle_d  = '0;
        end else begin
          wake_d = wake_q + 1'b1;
        end
      end
      default: begin
        state_d = ACTIVE;
        idle_d  = '0;
        wake_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ACTIVE;
      idle_q  <= '0;
      wake_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
    end
  end

  assign sram_volt_sel = resetn && (state_q == SLEEP);
  assign busy          = !resetn || !((state_q == SLEEP) && !any_valid);

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// tb/tb_sram_1rw_arbiter.sv - scoreboard bench for sram_1rw_arbiter with a cycle-level reference model
module tb_sram_1rw_arbiter;

  localparam int NP   = 2;
  localparam int IDLE = 8;
  localparam int WAKE = 3;

  logic              clock;
  logic              resetn;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_ready;
  logic [NP-1:0]     req_write;
  logic [NP*8-1:0]   req_addr;
  logic [NP*256-1:0] req_wdata;
  logic [NP-1:0]     rsp_valid;
  logic [255:0]      rsp_rdata;
  logic              sram_valid;
  logic              sram_write;
  logic [7:0]        sram_addr;
  logic [255:0]      sram_wdata;
  logic [255:0]      sram_rdata;
  logic              sram_volt_sel;
  logic              busy;

  sram_1rw_arbiter #(.NPORTS(NP), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .sram_valid   (sram_valid),
    .sram_write   (sram_write),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_volt_sel(sram_volt_sel),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [255:0] init_word(input int a);
    logic [31:0] w;
    w = 32'hC0DE0000 ^ (a * 32'h01010101) ^ 32'h5A;
    return {8{w}};
  endfunction

  // Behavioural 256x256 single-port macro: registered read data.
  logic [255:0] mac_mem [256];
  bit           mac_written [256];
  always @(posedge clock) begin
    if (sram_valid) begin
      if (sram_write) begin
        mac_mem[sram_addr]     <= sram_wdata;
        mac_written[sram_addr] <= 1'b1;
      end else begin
        sram_rdata <= mac_written[sram_addr] ? mac_mem[sram_addr] : init_word(int'(sram_addr));
      end
    end
  end

  typedef struct {
    int           port;
    int           cyc;
    logic [255:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Staged stimulus and reference-model state.
  logic         v_resetn;
  logic [NP-1:0] v_valid, v_write;
  logic [7:0]   v_addr [NP];
  logic [255:0] v_data [NP];
  logic [255:0] ref_mem [256];
  int m_mode;   // 0 active, 1 sleep, 2 wake
  int m_idle;   // consecutive idle active cycles
  int m_wake;   // wake cycles still to go
  int m_last;   // last granted port

  task automatic set_req(input int p, input logic w, input logic [7:0] a, input logic [255:0] d);
    v_valid[p] = 1'b1;
    v_write[p] = w;
    v_addr[p]  = a;
    v_data[p]  = d;
  endtask

  task automatic cycle();
    logic [NP-1:0] exp_rdy;
    logic          exp_volt, exp_busy;
    int            win;
    int            p;
    exp_t          e;
    @(negedge clock);
    resetn    = v_resetn;
    req_valid = v_valid;
    req_write = v_write;
    for (int i = 0; i < NP; i++) begin
      req_addr[i*8 +: 8]     = v_addr[i];
      req_wdata[i*256 +: 256] = v_data[i];
    end
    #1;
    exp_rdy  = '0;
    exp_volt = 1'b0;
    exp_busy = 1'b1;
    win      = -1;
    if (!v_resetn) begin
      m_mode = 0;
      m_idle = 0;
      m_wake = 0;
      m_last = NP - 1;
      while (exp_q.size() > 0 && exp_q[$].cyc == cyc) void'(exp_q.pop_back());
    end else if (m_mode == 0) begin
      if (v_valid != 0) begin
        for (int k = 1; k <= NP; k++) begin
          p = (m_last + k) % NP;
          if (win < 0 && v_valid[p]) win = p;
        end
        exp_rdy[win] = 1'b1;
        m_last = win;
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == IDLE) begin
          m_mode = 1;
          m_idle = 0;
        end
      end
    end else if (m_mode == 1) begin
      exp_volt = 1'b1;
      exp_busy = (v_valid != 0);
      if (v_valid != 0) begin
        m_mode = 2;
        m_wake = WAKE;
      end
    end else begin
      m_wake--;
      if (m_wake == 0) begin
        m_mode = 0;
        m_idle = 0;
      end
    end
    check("req_ready", req_ready, exp_rdy);
    check("volt_sel", sram_volt_sel, exp_volt);
    check("busy", busy, exp_busy);
    check("sram_valid", sram_valid, win >= 0);
    if (win >= 0) begin
      check("sram_write", sram_write, v_write[win]);
      check("sram_addr", sram_addr, v_addr[win]);
      if (v_write[win]) begin
        check("sram_wdata", sram_wdata, v_data[win]);
        ref_mem[v_addr[win]] = v_data[win];
      end else begin
        e.port = win;
        e.cyc  = cyc + 1;
        e.data = ref_mem[v_addr[win]];
        exp_q.push_back(e);
      end
      v_valid[win] = 1'b0;
    end
  endtask

  task automatic idle_to_sleep(output int quiet);
    quiet = 0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (sram_volt_sel) break;
      quiet++;
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (rsp_valid !== '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, '0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_port", rsp_valid, 1 << e.port);
          check("rsp_cycle", cyc, e.cyc);
          check("rsp_rdata", rsp_rdata, e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("rsp_missing", rsp_valid, 1 << e.port);
      end
    end
  end

  initial begin
    int q;
    int n;
    logic [255:0] d;
    v_resetn = 1'b0;
    v_valid  = '0;
    v_write  = '0;
    for (int i = 0; i < NP; i++) begin
      v_addr[i] = '0;
      v_data[i] = '0;
    end
    resetn    = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);
    m_mode = 0; m_idle = 0; m_wake = 0; m_last = NP - 1;

    cycle();
    cycle();
    v_resetn = 1'b1;

    // Write then read back on port 0.
    set_req(0, 1'b1, 8'h10, {32{8'hA5}});
    cycle();
    set_req(0, 1'b0, 8'h10, '0);
    cycle();
    cycle();

    // Pointer back to reset, then both ports contend for six cycles.
    v_resetn = 1'b0;
    cycle();
    v_resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1'b0, 8'h40, '0);
      set_req(1, 1'b0, 8'h41, '0);
      cycle();
      check("alt_grant", req_ready, 1 << (k % 2));
    end
    v_valid = '0;

    // Idle into SLEEP, then wake from a port 1 request.
    idle_to_sleep(q);
    check("idle_cycles", q, IDLE);
    set_req(1, 1'b0, 8'h20, '0);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (req_ready[1]) break;
      n++;
    end
    check("wake_latency", n, WAKE + 1);

    // Reads straddling the address wrap.
    set_req(0, 1'b0, 8'hFF, '0);
    cycle();
    set_req(1, 1'b0, 8'h00, '0);
    cycle();
    cycle();
    cycle();

    // Reset while waking.
    idle_to_sleep(q);
    d = {8{$urandom}};
    set_req(0, 1'b1, 8'h33, d);
    cycle();
    cycle();
    v_resetn = 1'b0;
    cycle();
    v_resetn = 1'b1;
    cycle();
    check("reset_wake_grant", req_ready, 1);
    check("reset_wake_volt", sram_volt_sel, 0);

    // Request withdrawn during SLEEP: WAKE completes and the idle count restarts.
    idle_to_sleep(q);
    set_req(1, 1'b0, 8'h05, '0);
    cycle();
    v_valid = '0;
    idle_to_sleep(q);
    check("wake_then_idle", q, WAKE + IDLE);

    // Randomised traffic with occasional idle stretches.
    for (int k = 0; k < 500; k++) begin
      if (v_valid == 0 && $urandom_range(0, 99) < 3) begin
        n = $urandom_range(1, IDLE + WAKE + 4);
        for (int j = 0; j < n; j++) cycle();
      end
      for (int p = 0; p < NP; p++) begin
        if (!v_valid[p] && $urandom_range(0, 99) < 40) begin
          for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
          case ($urandom_range(0, 3))
            0:       set_req(p, 1'($urandom_range(0, 1)), 8'h00, d);
            1:       set_req(p, 1'($urandom_range(0, 1)), 8'hFF, d);
            2:       set_req(p, 1'($urandom_range(0, 1)), 8'h10, d);
            default: set_req(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), d);
          endcase
        end
      end
      cycle();
    end

    v_valid = '0;
    for (int k = 0; k < 4; k++) cycle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_1rw_arbiter.md
# sram_1rw_arbiter

Controller that shares one `Sram_1rw_256x256` macro (256 words x 256 bits, single port) between NPORTS requesters with round-robin arbitration and fixed-latency read responses. It also drives the macro's `volt_sel` low-power control: after an idle threshold it drops the macro to low voltage, and on the next request it sequences a timed wake-up. The block sits between the vector load/store and DMA clients and the SRAM instance.

## Interface
Parameters:
- NPORTS, 2, number of requesters (2..4)
- IDLE_CYCLES, 64, consecutive idle cycles before entering low-voltage mode (>=1)
- WAKE_CYCLES, 4, stall cycles after leaving low-voltage mode before the first access (>=1)

Ports:
- clock  in  1  sole clock, rising edge
- resetn  in  1  synchronous reset, active-low
- req_valid  in  NPORTS  per-port request valid
- req_ready  out  NPORTS  per-port request accepted this cycle (one-hot or zero)
- req_write  in  NPORTS  per-port 1=write, 0=read
- req_addr  in  NPORTS*8  per-port word address, port i at [8i+7:8i]
- req_wdata  in  NPORTS*256  per-port write data, port i at [256i+255:256i]
- rsp_valid  out  NPORTS  read data valid for port i (one-hot or zero)
- rsp_rdata  out  256  read data, shared by all ports, qualified by rsp_valid
- sram_valid  out  1  to macro `valid`
- sram_write  out  1  to macro `write`
- sram_addr  out  8  to macro `addr`
- sram_wdata  out  256  to macro `wdata`
- sram_rdata  in  256  from macro `rdata`
- sram_volt_sel  out  1  to macro `volt_sel`; 1 = low voltage
- busy  out  1  high unless in SLEEP with no pending request

## Operation
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. req_ready depends combinationally on req_valid and on state. A requester must hold valid, write, addr and wdata stable until accepted.
- Arbitration (ACTIVE state only): round-robin over valid ports, starting from the port after the last granted port.
  - Last-granted pointer resets to NPORTS-1, so port 0 has first priority.
  - The pointer updates only on a grant.
  - At most one grant per cycle.
- A grant drives sram_valid=1 in the same cycle, with sram_write, sram_addr and sram_wdata muxed from the granted port. With no grant, sram_valid=0 and the other sram_* outputs are don't-care (drive 0).
- Read response:
  - An accepted read on port i in cycle N gives rsp_valid[i]=1 in cycle N+1, with rsp_rdata=sram_rdata (passed through combinationally).
  - There is no response backpressure. The client must sample in cycle N+1.
  - Writes produce no response.
- State machine, with state held in a register:
  - ACTIVE: grants are allowed. An idle counter increments each cycle with no req_valid and clears on any req_valid. When the counter reaches IDLE_CYCLES-1 and no req_valid is present, go to SLEEP.
  - SLEEP: sram_volt_sel=1, req_ready=0. Any req_valid moves the state to WAKE.
  - WAKE: sram_volt_sel=0, req_ready=0. A wake counter counts WAKE_CYCLES cycles, then the state moves to ACTIVE with the idle counter cleared.
- A request arriving in the same cycle as the ACTIVE->SLEEP transition is impossible, because the transition requires no req_valid. A request in the cycle a WAKE ends is granted in the first ACTIVE cycle.
- Reset: all counters clear, state=ACTIVE. This applies equally mid-WAKE or mid-SLEEP.

## Timing
- Output values while in reset: req_ready=0, rsp_valid=0, sram_valid=0, sram_volt_sel=0, busy=1, rsp_rdata=sram_rdata (don't-care).
- Latencies:
  - ACTIVE request to grant: 0 cycles if the port wins arbitration.
  - Read accept to rsp_valid: 1 cycle.
  - Request in SLEEP to first possible grant: WAKE_CYCLES+1 cycles.
- Throughput: one access per cycle. Back-to-back read then write, or write then read, to the same address is legal. The write is visible to a read granted in a later cycle.
- Idle counter width is $clog2(IDLE_CYCLES+1). Wake counter width is $clog2(WAKE_CYCLES+1). Neither counter wraps; each saturates or is cleared by the state change.
- Responses already in flight complete even if the next state is SLEEP. The pending rsp flag is independent of state.

## Structure
- Package `sram_arb_pkg` holds:
  - the state enum ACTIVE/SLEEP/WAKE (2 bits)
  - SRAM_AW=8 and SRAM_DW=256
- One sub-module, `rr_arbiter`, provides the parameterised round-robin grant logic (request vector, update enable, one-hot grant, pointer register). The top module instantiates it.

## Test plan
- Single port 0 writes 0xA5..A5 to addr 0x10, then reads addr 0x10. Required: rsp_valid[0] in the cycle after the read accept, rsp_rdata=0xA5..A5, no rsp on port 1.
- Both ports request continuously for 6 cycles. Required: grants alternate 0,1,0,1,0,1, and each port's req_ready is asserted every other cycle.
- Hold all req_valid low for IDLE_CYCLES. Required: sram_volt_sel rises exactly IDLE_CYCLES cycles after the last request. Then assert req_valid[1]. Required: req_ready[1] rises exactly WAKE_CYCLES+1 cycles later, with volt_sel=0 throughout WAKE.
- Reset (resetn=0 for 1 cycle) asserted mid-WAKE. Required: the next cycle is ACTIVE, volt_sel=0, and a pending request is granted immediately.
- A read of addr 0xFF on port 0 followed immediately by a read of addr 0x00 on port 1. Required: rsp_valid[0] and rsp_valid[1] on consecutive cycles, each with its own data, with no corruption at the address wrap.
- A request deasserted while in SLEEP before WAKE completes. Required: WAKE still finishes, state returns to ACTIVE, and the idle count restarts from 0.
